// File: rtl/mem_port_arb.sv
// Shares the core's single memory port between fetch, load and store requesters.
// Store > load > fetch priority; fetch wins once data-side grants reach STARVE_LIMIT.
module mem_port_arb #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          ld_ack_o,
  output logic [DW-1:0] ld_rdata_o,
  input  logic          st_req_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic [DW-1:0] st_data_i,
  output logic          st_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          arb_busy_o
);

  localparam int            CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {
    OWN_FETCH = 2'd0,
    OWN_LOAD  = 2'd1,
    OWN_STORE = 2'd2
  } owner_t;

  state_t        state_r;
  state_t        state_nxt_s;
  owner_t        owner_r;
  owner_t        grant_owner_s;
  logic [CW-1:0] starve_cnt_r;
  logic [CW-1:0] starve_nxt_s;
  logic          drop_r;
  logic          grant_s;
  logic          complete_s;
  logic          grant_we_s;
  logic [AW-1:0] grant_addr_s;
  logic [DW-1:0] grant_wdata_s;
  logic          if_elig_s;
  logic          ld_elig_s;
  logic          st_elig_s;

  // A requester whose ack is pulsing this cycle is still holding req; keep it out.
  assign if_elig_s  = if_req_i & ~if_ack_o & ~if_flush_i;
  assign ld_elig_s  = ld_req_i & ~ld_ack_o;
  assign st_elig_s  = st_req_i & ~st_ack_o;
  assign arb_busy_o = (state_r == BUSY);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, arbitration winner and completion detect
  always_comb begin
    state_nxt_s   = state_r;
    grant_s       = 1'b0;
    complete_s    = 1'b0;
    grant_owner_s = OWN_FETCH;
    case (state_r)
      IDLE: begin
        if (if_elig_s && (starve_cnt_r == STARVE_MAX)) begin
          grant_s       = 1'b1;
          grant_owner_s = OWN_FETCH;
        end else if (st_elig_s) begin
          grant_s       = 1'b1;
          grant_owner_s = OWN_STORE;
        end else if (ld_elig_s) begin
          grant_s       = 1'b1;
          grant_owner_s = OWN_LOAD;
        end else if (if_elig_s) begin
          grant_s       = 1'b1;
          grant_owner_s = OWN_FETCH;
        end else begin
          grant_s       = 1'b0;
        end
        state_nxt_s = grant_s ? BUSY : IDLE;
      end
      BUSY: begin
        if (mem_ack_i) begin
          complete_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory-port payload for the winner and next starvation count
  always_comb begin
    grant_we_s    = 1'b0;
    grant_addr_s  = if_addr_i;
    grant_wdata_s = {DW{1'b0}};
    starve_nxt_s  = starve_cnt_r;
    case (grant_owner_s)
      OWN_STORE: begin
        grant_we_s    = 1'b1;
        grant_addr_s  = st_addr_i;
        grant_wdata_s = st_data_i;
      end
      OWN_LOAD: begin
        grant_addr_s  = ld_addr_i;
      end
      OWN_FETCH: begin
        grant_addr_s  = if_addr_i;
      end
      default: begin
        grant_addr_s  = if_addr_i;
      end
    endcase
    if (!grant_s) begin
      starve_nxt_s = starve_cnt_r;
    end else if ((grant_owner_s == OWN_FETCH) || !if_req_i) begin
      starve_nxt_s = {CW{1'b0}};
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_nxt_s = starve_cnt_r + CW'(1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Memory port, response pulses, starvation counter and fetch drop flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= {AW{1'b0}};
      mem_wdata_o  <= {DW{1'b0}};
      if_ack_o     <= 1'b0;
      ld_ack_o     <= 1'b0;
      st_ack_o     <= 1'b0;
      if_rdata_o   <= {DW{1'b0}};
      ld_rdata_o   <= {DW{1'b0}};
      owner_r      <= OWN_FETCH;
      starve_cnt_r <= {CW{1'b0}};
      drop_r       <= 1'b0;
    end else begin
      if_ack_o     <= 1'b0;
      ld_ack_o     <= 1'b0;
      st_ack_o     <= 1'b0;
      starve_cnt_r <= starve_nxt_s;
      if (grant_s) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= grant_we_s;
        mem_addr_o  <= grant_addr_s;
        mem_wdata_o <= grant_wdata_s;
        owner_r     <= grant_owner_s;
        drop_r      <= 1'b0;
      end else if (complete_s) begin
        mem_req_o   <= 1'b0;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= {AW{1'b0}};
        mem_wdata_o <= {DW{1'b0}};
        drop_r      <= 1'b0;
        // A flush arriving together with the memory ack still cancels the fetch.
        case (owner_r)
          OWN_FETCH: begin
            if_rdata_o <= mem_rdata_i;
            if_ack_o   <= ~(drop_r | if_flush_i);
          end
          OWN_LOAD: begin
            ld_rdata_o <= mem_rdata_i;
            ld_ack_o   <= 1'b1;
          end
          OWN_STORE: begin
            st_ack_o   <= 1'b1;
          end
          default: begin
            st_ack_o   <= 1'b0;
          end
        endcase
      end else if ((state_r == BUSY) && (owner_r == OWN_FETCH) && if_flush_i) begin
        drop_r <= 1'b1;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush, ld_req, st_req, mem_ack;
  logic [AW-1:0] if_addr, ld_addr, st_addr;
  logic [DW-1:0] st_data, mem_rdata;
  logic          if_ack_o, ld_ack_o, st_ack_o, mem_req_o, mem_we_o, arb_busy_o;
  logic [DW-1:0] if_rdata_o, ld_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
    .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data), .st_ack_o(st_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .arb_busy_o(arb_busy_o)
  );

  function automatic logic [133:0] outs();
    return {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, ld_ack_o, st_ack_o,
            if_rdata_o, ld_rdata_o, arb_busy_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ld_req = 1'b0; ld_addr = '0;
    st_req = 1'b0; st_addr = '0; st_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== {134{1'b0}}) begin
      bad++; $display("FAIL reset_assert got=%h exp=0", outs());
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (outs() !== {134{1'b0}}) begin
      bad++; $display("FAIL reset_held got=%h exp=0", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (outs() !== {134{1'b0}}) begin
      bad++; $display("FAIL reset_release got=%h exp=0", outs());
    end
  endtask

  task automatic test_single_load();
    logic [AW-1:0] a;
    int extra = 0;
    a = $urandom;
    ld_addr = a; ld_req = 1'b1;
    tick();
    total++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, a, 32'h0}) begin
      bad++; $display("FAIL load_issue got=%b/%b/%h/%h exp=1/0/%h/0",
                      mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, a);
    end
    tick();
    total++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, a}) begin
      bad++; $display("FAIL load_hold got=%b/%h exp=1/%h", mem_req_o, mem_addr_o, a);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = $urandom;
    total++;
    if ({ld_ack_o, ld_rdata_o, mem_req_o, st_ack_o, if_ack_o} !== {1'b1, 32'hDEADBEEF, 3'b000}) begin
      bad++; $display("FAIL load_ack got=%b/%h/%b exp=1/deadbeef/0", ld_ack_o, ld_rdata_o, mem_req_o);
    end
    ld_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_req_o || ld_ack_o) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL load_single_grant got=%0d extra cycles exp=0", extra);
    end
  endtask

  task automatic test_priority();
    logic [AW-1:0] xa [3];
    logic [DW-1:0] sd;
    int rise_cyc [3];
    int n = 0;
    int st_n = 0, ld_n = 0, if_n = 0;
    logic prev = 1'b0;
    xa[0] = $urandom; xa[1] = $urandom; xa[2] = $urandom; sd = $urandom;
    st_addr = xa[0]; st_data = sd; ld_addr = xa[1]; if_addr = xa[2];
    st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (st_ack_o) begin st_req = 1'b0; st_n++; end
      if (ld_ack_o) begin ld_req = 1'b0; ld_n++; end
      if (if_ack_o) begin if_req = 1'b0; if_n++; end
      if (mem_req_o && !prev) begin
        total++;
        if (n > 2) begin
          bad++; $display("FAIL prio_extra_grant got=%0d grants exp=3", n + 1);
        end else if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {(n == 0), xa[n], (n == 0) ? sd : 32'h0}) begin
          bad++; $display("FAIL prio_order slot=%0d got=%b/%h/%h exp=%b/%h", n,
                          mem_we_o, mem_addr_o, mem_wdata_o, (n == 0), xa[n]);
        end
        if (n <= 2) rise_cyc[n] = c;
        n++;
      end
      mem_ack = mem_req_o && prev;
      prev = mem_req_o;
    end
    mem_ack = 1'b0;
    total++;
    if (n != 3 || rise_cyc[0] != 1 || rise_cyc[1] != 4 || rise_cyc[2] != 7) begin
      bad++; $display("FAIL prio_timing got n=%0d rises=%0d,%0d,%0d exp=3 rises=1,4,7",
                      n, rise_cyc[0], rise_cyc[1], rise_cyc[2]);
    end
    total++;
    if (st_n != 1 || ld_n != 1 || if_n != 1) begin
      bad++; $display("FAIL prio_acks got st=%0d ld=%0d if=%0d exp=1 each", st_n, ld_n, if_n);
    end
  endtask

  task automatic test_starvation();
    int data_g = 0, fetch_g = 0;
    logic prev = 1'b0;
    do_reset();
    if_addr = {4'h1, 28'($urandom)}; if_req = 1'b1;
    ld_addr = {4'h2, 28'($urandom)}; ld_req = 1'b1;
    st_addr = {4'h3, 28'($urandom)}; st_data = $urandom; st_req = 1'b1;
    for (int c = 0; c < 300 && fetch_g < 2; c++) begin
      tick();
      if (mem_req_o && !prev) begin
        if (mem_addr_o[31:28] == 4'h1) begin
          total++;
          if (data_g != SL) begin
            bad++; $display("FAIL starve_window got=%0d data grants exp=%0d", data_g, SL);
          end
          fetch_g++;
          data_g = 0;
        end else begin
          data_g++;
        end
      end
      prev = mem_req_o;
      mem_ack = mem_req_o;
      if (if_ack_o) if_addr = {4'h1, 28'($urandom)};
      if (ld_ack_o) ld_addr = {4'h2, 28'($urandom)};
      if (st_ack_o) begin st_addr = {4'h3, 28'($urandom)}; st_data = $urandom; end
    end
    total++;
    if (fetch_g != 2) begin
      bad++; $display("FAIL starve_fetch_grants got=%0d exp=2", fetch_g);
    end
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    repeat (4) begin tick(); mem_ack = mem_req_o; end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [AW-1:0] fa, la;
    logic [DW-1:0] rd;
    int seen = 0;
    fa = $urandom; la = $urandom; rd = $urandom;
    if_addr = fa; if_req = 1'b1;
    tick();
    total++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, fa}) begin
      bad++; $display("FAIL flush_grant got=%b/%b/%h exp=1/0/%h", mem_req_o, mem_we_o, mem_addr_o, fa);
    end
    for (int c = 0; c < 5; c++) begin
      if_flush = (c == 1);
      if (c == 1) if_req = 1'b0;
      tick();
      if (if_ack_o) seen++;
      total++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, fa}) begin
        bad++; $display("FAIL flush_hold got=%b/%h exp=1/%h", mem_req_o, mem_addr_o, fa);
      end
    end
    if_flush = 1'b0; mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({if_ack_o, mem_req_o, arb_busy_o} !== 3'b000) begin
      bad++; $display("FAIL flush_drop got=%b%b%b exp=000", if_ack_o, mem_req_o, arb_busy_o);
    end
    tick();
    if (if_ack_o) seen++;
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL flush_no_ack got=%0d pulses exp=0", seen);
    end
    ld_addr = la; ld_req = 1'b1;
    tick();
    total++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, la}) begin
      bad++; $display("FAIL flush_next_grant got=%b/%h exp=1/%h", mem_req_o, mem_addr_o, la);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; ld_req = 1'b0;
    total++;
    if ({ld_ack_o, ld_rdata_o} !== {1'b1, rd}) begin
      bad++; $display("FAIL flush_next_ack got=%b/%h exp=1/%h", ld_ack_o, ld_rdata_o, rd);
    end
    if_addr = $urandom; if_req = 1'b1;
    tick();
    if_flush = 1'b1; if_req = 1'b0; mem_ack = 1'b1;
    tick();
    if_flush = 1'b0; mem_ack = 1'b0;
    total++;
    if ({if_ack_o, arb_busy_o} !== 2'b00) begin
      bad++; $display("FAIL flush_with_ack got=%b%b exp=00", if_ack_o, arb_busy_o);
    end
    tick();
    total++;
    if ({if_ack_o, mem_req_o} !== 2'b00) begin
      bad++; $display("FAIL flush_with_ack_after got=%b%b exp=00", if_ack_o, mem_req_o);
    end
  endtask

  task automatic test_zero_latency();
    int last = -1;
    int acks = 0;
    logic prev_ack = 1'b0;
    mem_ack = 1'b1; ld_addr = $urandom; ld_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (prev_ack) begin
        total++;
        if (mem_req_o !== 1'b0) begin
          bad++; $display("FAIL zl_dup_grant cycle=%0d got=%b exp=0", c, mem_req_o);
        end
      end
      if (ld_ack_o) begin
        if (last >= 0) begin
          total++;
          if (c - last != 3) begin
            bad++; $display("FAIL zl_period got=%0d exp=3", c - last);
          end
        end
        last = c;
        acks++;
        ld_addr = $urandom;
      end
      prev_ack = ld_ack_o;
    end
    total++;
    if (acks != 13) begin
      bad++; $display("FAIL zl_ack_count got=%0d exp=13", acks);
    end
    ld_req = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int errs = 0;
    ld_addr = $urandom; ld_req = 1'b1;
    tick();
    total++;
    if ({mem_req_o, arb_busy_o} !== 2'b11) begin
      bad++; $display("FAIL rst_busy_setup got=%b%b exp=11", mem_req_o, arb_busy_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== {134{1'b0}}) begin
      bad++; $display("FAIL rst_mid_busy got=%h exp=0", outs());
    end
    ld_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = $urandom;
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_ack = 1'b0;
      total++;
      if ({if_ack_o, ld_ack_o, st_ack_o, mem_req_o, arb_busy_o} !== 5'b00000) begin
        bad++; errs++;
        $display("FAIL rst_late_ack got=%b%b%b%b%b exp=00000",
                 if_ack_o, ld_ack_o, st_ack_o, mem_req_o, arb_busy_o);
      end
    end
  endtask

  task automatic test_random();
    logic          m_busy = 1'b0, m_we = 1'b0, m_drop = 1'b0;
    int            m_owner = 0, m_starve = 0, w;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, x_if_rd = '0, x_ld_rd = '0;
    logic          e_if = 1'b0, e_ld = 1'b0, e_st = 1'b0, pe_if, pe_ld, pe_st;
    logic          ef, el, es;
    logic          p_ifr = 1'b0, p_ldr = 1'b0, p_str = 1'b0, p_flush = 1'b0, p_ack = 1'b0;
    logic [AW-1:0] p_ifa = '0, p_lda = '0, p_sta = '0;
    logic [DW-1:0] p_std = '0, p_rd = '0;
    logic          f_pend = 1'b0, l_pend = 1'b0, s_pend = 1'b0, r_active = 1'b0;
    int            r_wait = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      tick();
      pe_if = e_if; pe_ld = e_ld; pe_st = e_st;
      e_if = 1'b0; e_ld = 1'b0; e_st = 1'b0;
      if (m_busy) begin
        if (p_flush && m_owner == 0) m_drop = 1'b1;
        if (p_ack) begin
          m_busy = 1'b0;
          if (m_owner == 0) begin e_if = !m_drop; x_if_rd = p_rd; end
          else if (m_owner == 1) begin e_ld = 1'b1; x_ld_rd = p_rd; end
          else e_st = 1'b1;
        end
      end else begin
        ef = p_ifr && !pe_if && !p_flush;
        el = p_ldr && !pe_ld;
        es = p_str && !pe_st;
        if (ef || el || es) begin
          if (ef && m_starve == SL) w = 0;
          else if (es) w = 2;
          else if (el) w = 1;
          else w = 0;
          m_busy = 1'b1; m_owner = w; m_drop = 1'b0;
          m_we = (w == 2);
          m_addr = (w == 0) ? p_ifa : (w == 1) ? p_lda : p_sta;
          m_wdata = (w == 2) ? p_std : '0;
          if (w == 0 || !p_ifr) m_starve = 0;
          else if (m_starve < SL) m_starve++;
        end
      end
      total++;
      if (mem_req_o !== m_busy || arb_busy_o !== m_busy) begin
        bad++; $display("FAIL rnd_busy cycle=%0d got=%b%b exp=%b", c, mem_req_o, arb_busy_o, m_busy);
      end
      if (m_busy) begin
        total++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {m_we, m_addr, m_wdata}) begin
          bad++; $display("FAIL rnd_port cycle=%0d got=%b/%h/%h exp=%b/%h/%h", c,
                          mem_we_o, mem_addr_o, mem_wdata_o, m_we, m_addr, m_wdata);
        end
      end
      total++;
      if ({if_ack_o, ld_ack_o, st_ack_o} !== {e_if, e_ld, e_st}) begin
        bad++; $display("FAIL rnd_acks cycle=%0d got=%b%b%b exp=%b%b%b", c,
                        if_ack_o, ld_ack_o, st_ack_o, e_if, e_ld, e_st);
      end
      if (e_if) begin
        total++;
        if (if_rdata_o !== x_if_rd) begin
          bad++; $display("FAIL rnd_if_rdata got=%h exp=%h", if_rdata_o, x_if_rd);
        end
      end
      if (e_ld) begin
        total++;
        if (ld_rdata_o !== x_ld_rd) begin
          bad++; $display("FAIL rnd_ld_rdata got=%h exp=%h", ld_rdata_o, x_ld_rd);
        end
      end
      if (if_ack_o) f_pend = 1'b0;
      if_flush = ($urandom_range(0, 15) == 0);
      if (if_flush) f_pend = 1'b0;
      if (!f_pend && $urandom_range(0, 1) == 1) begin f_pend = 1'b1; if_addr = $urandom; end
      if (ld_ack_o) l_pend = 1'b0;
      if (!l_pend && $urandom_range(0, 2) == 0) begin l_pend = 1'b1; ld_addr = $urandom; end
      if (st_ack_o) s_pend = 1'b0;
      if (!s_pend && $urandom_range(0, 2) == 0) begin
        s_pend = 1'b1; st_addr = $urandom; st_data = $urandom;
      end
      if_req = f_pend; ld_req = l_pend; st_req = s_pend;
      mem_rdata = $urandom;
      if (mem_req_o) begin
        if (!r_active) begin r_active = 1'b1; r_wait = $urandom_range(0, 3); end
        if (r_wait == 0) begin mem_ack = 1'b1; r_active = 1'b0; end
        else begin r_wait--; mem_ack = 1'b0; end
      end else begin
        r_active = 1'b0;
        mem_ack = ($urandom_range(0, 7) == 0);
      end
      p_ifr = if_req; p_ldr = ld_req; p_str = st_req; p_flush = if_flush; p_ack = mem_ack;
      p_ifa = if_addr; p_lda = ld_addr; p_sta = st_addr; p_std = st_data; p_rd = mem_rdata;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_single_load();
    test_priority();
    test_starvation();
    test_flush();
    test_zero_latency();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer sharing the core's single memory port between instruction fetch, execute-stage loads and execute-stage stores. It sits between the fetch/execute stages and the memory. The block registers one transaction at a time and holds it on the memory port until memory acknowledges. It returns read data or completion to the winning requester, and applies store > load > fetch priority with a starvation guard for fetch.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive data-side grants allowed while fetch waits (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until if_ack_o or flush
- if_addr_i  in  AW  fetch address
- if_flush_i  in  1  cancel fetch (PC redirect)
- if_ack_o  out  1  one-cycle fetch completion
- if_rdata_o  out  DW  fetched word, valid with if_ack_o
- ld_req_i  in  1  load request, held until ld_ack_o
- ld_addr_i  in  AW  load address
- ld_ack_o  out  1  one-cycle load completion
- ld_rdata_o  out  DW  load data, valid with ld_ack_o
- st_req_i  in  1  store request, held until st_ack_o
- st_addr_i  in  AW  store address
- st_data_i  in  DW  store data
- st_ack_o  out  1  one-cycle store completion
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  1 = write
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  write data (0 on reads)
- mem_rdata_i  in  DW  read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, any latency ≥0 cycles after mem_req_o rises
- arb_busy_o  out  1  transaction outstanding (state BUSY)

## Operation
- FSM: IDLE, BUSY. Registered grant: owner ∈ {FETCH, LOAD, STORE}, latched addr/data/we.
- IDLE: eligible requests = req_i AND NOT own ack_o this cycle (prevents re-grant of a just-completed requester). If any is eligible, grant one, latch its addr/data, drive mem_* next cycle, → BUSY.
- Priority: STORE > LOAD > FETCH, except when starve_cnt == STARVE_LIMIT and fetch is eligible; then FETCH wins.
- starve_cnt (clog2(STARVE_LIMIT+1) bits, saturating): +1 on a LOAD/STORE grant with if_req_i high; cleared on FETCH grant, or on any grant with if_req_i low.
- BUSY: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o held stable. When mem_ack_i = 1: capture mem_rdata_i into owner's rdata register, pulse owner's ack_o next cycle, → IDLE.
- Flush: if_flush_i while owner = FETCH in BUSY sets a drop flag. The memory transaction still completes (mem_req_o is not withdrawn), but if_ack_o is suppressed. if_flush_i in IDLE blocks a fetch grant that cycle. Flush does not affect load/store.
- mem_ack_i while IDLE: ignored.
- rdata outputs hold last captured value between acks; only meaningful with ack.

## Timing
- Reset (async assert, sync-free deassert): state IDLE, all outputs 0, starve_cnt 0, drop flag 0. mem_req_o falls immediately; an in-flight transaction is abandoned and its late mem_ack_i is ignored.
- Request eligible in IDLE at cycle N → mem_req_o = 1 at N+1.
- mem_ack_i sampled at cycle M ≥ N+1 → ack_o and rdata at M+1; state IDLE at M+1.
- Earliest next mem_req_o: M+2 (arbitration at M+1). Back-to-back throughput: one transaction per 3 cycles with zero-wait memory.
- Simultaneous flush and mem_ack_i on a fetch: the response is dropped.
- Simultaneous requests: resolved in a single cycle by priority; the losers keep waiting.

## Test plan
- Single load, mem_ack_i 2 cycles after mem_req_o, rdata 0xDEADBEEF -> mem_req_o high 2 cycles with mem_we_o 0; ld_ack_o one cycle after ack with ld_rdata_o 0xDEADBEEF; only one grant occurs.
- if/ld/st requested in the same cycle, zero-wait memory -> order STORE (mem_we_o 1, st_data_i on mem_wdata_o), LOAD, FETCH; mem_req_o rises at cycles 1, 4, 7.
- if_req_i held while ld/st alternate continuously, STARVE_LIMIT 4 -> fetch is granted after exactly 4 data-side grants; starve_cnt returns to 0.
- Fetch granted; if_flush_i pulsed while memory stalls 5 cycles -> mem_req_o stays high until ack; if_ack_o never asserts; the next request is granted normally.
- rst_n_i asserted mid-BUSY, then mem_ack_i arrives after release -> all outputs 0 immediately; no ack_o pulses; arb_busy_o 0.
- Zero-latency memory (mem_ack_i tied 1) with a continuous load request -> ld_ack_o every 3 cycles, no duplicate grant in an ack cycle.
